// File: rtl/ice40_ebr_pkg.sv
// Shared mode encoding and width helpers for the configurable 4 kbit block RAM.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ice40_ebr_pkg;

    // Geometry encodings shared by the read and write ports
    localparam int unsigned MODE_256X16 = 0;
    localparam int unsigned MODE_512X8  = 1;
    localparam int unsigned MODE_1024X4 = 2;
    localparam int unsigned MODE_2048X2 = 3;
    localparam int unsigned MODE_MAX    = MODE_2048X2;

    // Physical array shape: every geometry is a view onto 256 rows of 16 bits
    localparam int unsigned PHYS_ROWS   = 256;
    localparam int unsigned PHYS_WIDTH  = 16;
    localparam int unsigned ROW_AW      = 8;

    // Word address width for a given geometry
    function automatic int unsigned addr_width(input int unsigned mode);
        return ROW_AW + mode;
    endfunction

    // Word data width for a given geometry
    function automatic int unsigned data_width(input int unsigned mode);
        return PHYS_WIDTH >> mode;
    endfunction

endpackage

// File: rtl/ice40_ebr_mem.sv
// Physical 256x16 array with per-bit write enable and one registered read port.
// Latency: 1 cycle from rd_ena/rd_row sample to rd_word; read-during-write returns old data.
// Backpressure: none; accepts one read and one write every cycle.
module ice40_ebr_mem
    import ice40_ebr_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_ena,
    input  logic [ROW_AW-1:0]       wr_row,
    input  logic [PHYS_WIDTH-1:0]   wr_bit_en,
    input  logic [PHYS_WIDTH-1:0]   wr_word,
    input  logic                    rd_ena,
    input  logic [ROW_AW-1:0]       rd_row,
    output logic [PHYS_WIDTH-1:0]   rd_word
);

    logic [PHYS_WIDTH-1:0] mem_q [PHYS_ROWS];
    logic [PHYS_WIDTH-1:0] rd_word_d;
    logic [PHYS_WIDTH-1:0] rd_word_q;

    // Array write: contents survive reset, but no write lands while reset is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // storage intentionally left untouched
        end else if (wr_ena) begin
            for (int j = 0; j < int'(PHYS_WIDTH); j++) begin
                if (wr_bit_en[j]) begin
                    mem_q[wr_row][j] <= wr_word[j];
                end
            end
        end
    end

    // Next read word: load on rd_ena, otherwise hold
    always_comb begin
        rd_word_d = rd_word_q;
        if (rd_ena) begin
            rd_word_d = mem_q[rd_row];
        end
    end

    // Read register; samples the array before this edge's write, giving old data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_word_q <= '0;
        end else begin
            rd_word_q <= rd_word_d;
        end
    end

    assign rd_word = rd_word_q;

endmodule

// File: rtl/ice40_ebr.sv
// Configurable-geometry 4 kbit block RAM: independent read/write widths over one 256x16 array.
// Latency: 1 cycle read; write visible to reads issued on the following cycle.
// Backpressure: none; one read and one write accepted every cycle.
module ice40_ebr
    import ice40_ebr_pkg::*;
#(
    parameter int unsigned READ_MODE       = 2,
    parameter int unsigned WRITE_MODE      = 1,
    parameter int unsigned MASK_WORKAROUND = 1,
    localparam int unsigned WAW = addr_width(WRITE_MODE),
    localparam int unsigned WDW = data_width(WRITE_MODE),
    localparam int unsigned RAW = addr_width(READ_MODE),
    localparam int unsigned RDW = data_width(READ_MODE)
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WAW-1:0]  wr_addr,
    input  logic [WDW-1:0]  wr_data,
    input  logic [WDW-1:0]  wr_mask,
    input  logic            wr_ena,
    input  logic [RAW-1:0]  rd_addr,
    output logic [RDW-1:0]  rd_data,
    input  logic            rd_ena
);

    // Refuse to build with a geometry code outside 0..3
    if (READ_MODE > MODE_MAX || WRITE_MODE > MODE_MAX) begin : g_bad_mode
        $error("ice40_ebr: READ_MODE and WRITE_MODE must be in 0..3");
    end

    // Native silicon ignores the mask in narrow write modes; 16-bit mode always honours it
    localparam bit MASK_HONOURED = (MASK_WORKAROUND != 0) || (WRITE_MODE == MODE_256X16);

    // Low address bits select the lane within a 16-bit physical row
    localparam logic [WAW-1:0] WR_LANE_MASK = WAW'((1 << WRITE_MODE) - 1);
    localparam logic [RAW-1:0] RD_LANE_MASK = RAW'((1 << READ_MODE) - 1);

    logic [ROW_AW-1:0]      wr_row;
    logic [3:0]             wr_lane;
    logic [WDW-1:0]         wr_mask_eff;
    logic [PHYS_WIDTH-1:0]  wr_bit_en;
    logic [PHYS_WIDTH-1:0]  wr_word;
    logic [ROW_AW-1:0]      rd_row;
    logic [3:0]             rd_lane_d;
    logic [3:0]             rd_lane_q;
    logic [PHYS_WIDTH-1:0]  rd_word;

    // Write geometry: replicate data into every lane, enable only unmasked bits of the addressed lane
    always_comb begin
        wr_row      = ROW_AW'(wr_addr >> WRITE_MODE);
        wr_lane     = 4'(wr_addr & WR_LANE_MASK);
        wr_mask_eff = MASK_HONOURED ? wr_mask : '0;
        wr_bit_en   = '0;
        wr_word     = '0;
        for (int j = 0; j < int'(PHYS_WIDTH); j++) begin
            wr_word[j] = wr_data[j % int'(WDW)];
            if (4'(j / int'(WDW)) == wr_lane) begin
                wr_bit_en[j] = ~wr_mask_eff[j % int'(WDW)];
            end
        end
    end

    // Read geometry: row goes to the array now, lane is remembered for the output mux
    always_comb begin
        rd_row    = ROW_AW'(rd_addr >> READ_MODE);
        rd_lane_d = rd_lane_q;
        if (rd_ena) begin
            rd_lane_d = 4'(rd_addr & RD_LANE_MASK);
        end
    end

    // Lane register tracks the word held in the array's read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_lane_q <= '0;
        end else begin
            rd_lane_q <= rd_lane_d;
        end
    end

    ice40_ebr_mem u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_ena    (wr_ena),
        .wr_row    (wr_row),
        .wr_bit_en (wr_bit_en),
        .wr_word   (wr_word),
        .rd_ena    (rd_ena),
        .rd_row    (rd_row),
        .rd_word   (rd_word)
    );

    // Output lane select; read register resets to zero so rd_data does too
    assign rd_data = rd_word[int'(rd_lane_q) * int'(RDW) +: RDW];

endmodule

// File: tb/tb_ice40_ebr.sv
// Directed bench for ice40_ebr across several read/write geometry pairs.
// Inputs driven on the falling edge, outputs sampled on the falling edge after the sampling rising edge.
// No backpressure in the design; every transaction takes a fixed number of cycles.
module tb_ice40_ebr;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // default geometry: 512x8 write, 1024x4 read
    logic [8:0]  d_wr_addr;
    logic [7:0]  d_wr_data;
    logic [7:0]  d_wr_mask;
    logic        d_wr_ena;
    logic [9:0]  d_rd_addr;
    logic        d_rd_ena;
    logic [3:0]  d_rd_data;

    // 512x8 both ports, shared stimulus, with and without mask workaround
    logic [8:0]  m_wr_addr;
    logic [7:0]  m_wr_data;
    logic [7:0]  m_wr_mask;
    logic        m_wr_ena;
    logic [8:0]  m_rd_addr;
    logic        m_rd_ena;
    logic [7:0]  m1_rd_data;
    logic [7:0]  m0_rd_data;

    // 256x16 both ports, workaround off (mask must still be honoured)
    logic [7:0]  z_wr_addr;
    logic [15:0] z_wr_data;
    logic [15:0] z_wr_mask;
    logic        z_wr_ena;
    logic [7:0]  z_rd_addr;
    logic        z_rd_ena;
    logic [15:0] z_rd_data;

    // 2048x2 write, 256x16 read
    logic [10:0] q_wr_addr;
    logic [1:0]  q_wr_data;
    logic [1:0]  q_wr_mask;
    logic        q_wr_ena;
    logic [7:0]  q_rd_addr;
    logic        q_rd_ena;
    logic [15:0] q_rd_data;

    logic [7:0]  exp_byte [512];

    ice40_ebr u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_addr(d_wr_addr), .wr_data(d_wr_data), .wr_mask(d_wr_mask), .wr_ena(d_wr_ena),
        .rd_addr(d_rd_addr), .rd_data(d_rd_data), .rd_ena(d_rd_ena)
    );

    ice40_ebr #(.READ_MODE(1), .WRITE_MODE(1), .MASK_WORKAROUND(1)) u_m1 (
        .clk(clk), .rst_n(rst_n),
        .wr_addr(m_wr_addr), .wr_data(m_wr_data), .wr_mask(m_wr_mask), .wr_ena(m_wr_ena),
        .rd_addr(m_rd_addr), .rd_data(m1_rd_data), .rd_ena(m_rd_ena)
    );

    ice40_ebr #(.READ_MODE(1), .WRITE_MODE(1), .MASK_WORKAROUND(0)) u_m0 (
        .clk(clk), .rst_n(rst_n),
        .wr_addr(m_wr_addr), .wr_data(m_wr_data), .wr_mask(m_wr_mask), .wr_ena(m_wr_ena),
        .rd_addr(m_rd_addr), .rd_data(m0_rd_data), .rd_ena(m_rd_ena)
    );

    ice40_ebr #(.READ_MODE(0), .WRITE_MODE(0), .MASK_WORKAROUND(0)) u_z (
        .clk(clk), .rst_n(rst_n),
        .wr_addr(z_wr_addr), .wr_data(z_wr_data), .wr_mask(z_wr_mask), .wr_ena(z_wr_ena),
        .rd_addr(z_rd_addr), .rd_data(z_rd_data), .rd_ena(z_rd_ena)
    );

    ice40_ebr #(.READ_MODE(0), .WRITE_MODE(3), .MASK_WORKAROUND(1)) u_q (
        .clk(clk), .rst_n(rst_n),
        .wr_addr(q_wr_addr), .wr_data(q_wr_data), .wr_mask(q_wr_mask), .wr_ena(q_wr_ena),
        .rd_addr(q_rd_addr), .rd_data(q_rd_data), .rd_ena(q_rd_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic d_write(input logic [8:0] a, input logic [7:0] dat, input logic [7:0] msk);
        @(negedge clk);
        d_wr_addr = a; d_wr_data = dat; d_wr_mask = msk; d_wr_ena = 1'b1;
        @(negedge clk);
        d_wr_ena = 1'b0;
    endtask

    task automatic d_read(input logic [9:0] a, output logic [3:0] q);
        @(negedge clk);
        d_rd_addr = a; d_rd_ena = 1'b1;
        @(negedge clk);
        d_rd_ena = 1'b0;
        q = d_rd_data;
    endtask

    task automatic m_write(input logic [8:0] a, input logic [7:0] dat, input logic [7:0] msk);
        @(negedge clk);
        m_wr_addr = a; m_wr_data = dat; m_wr_mask = msk; m_wr_ena = 1'b1;
        @(negedge clk);
        m_wr_ena = 1'b0;
    endtask

    task automatic m_read(input logic [8:0] a, output logic [7:0] q1, output logic [7:0] q0);
        @(negedge clk);
        m_rd_addr = a; m_rd_ena = 1'b1;
        @(negedge clk);
        m_rd_ena = 1'b0;
        q1 = m1_rd_data;
        q0 = m0_rd_data;
    endtask

    task automatic z_write(input logic [7:0] a, input logic [15:0] dat, input logic [15:0] msk);
        @(negedge clk);
        z_wr_addr = a; z_wr_data = dat; z_wr_mask = msk; z_wr_ena = 1'b1;
        @(negedge clk);
        z_wr_ena = 1'b0;
    endtask

    task automatic z_read(input logic [7:0] a, output logic [15:0] q);
        @(negedge clk);
        z_rd_addr = a; z_rd_ena = 1'b1;
        @(negedge clk);
        z_rd_ena = 1'b0;
        q = z_rd_data;
    endtask

    task automatic q_write(input logic [10:0] a, input logic [1:0] dat);
        @(negedge clk);
        q_wr_addr = a; q_wr_data = dat; q_wr_mask = 2'b00; q_wr_ena = 1'b1;
        @(negedge clk);
        q_wr_ena = 1'b0;
    endtask

    task automatic q_read(input logic [7:0] a, output logic [15:0] q);
        @(negedge clk);
        q_rd_addr = a; q_rd_ena = 1'b1;
        @(negedge clk);
        q_rd_ena = 1'b0;
        q = q_rd_data;
    endtask

    initial begin
        logic [3:0]  nib;
        logic [3:0]  held;
        logic [7:0]  r1;
        logic [7:0]  r0;
        logic [15:0] w16;
        logic [1:0]  pairs [8];

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        d_wr_addr = '0; d_wr_data = '0; d_wr_mask = '0; d_wr_ena = 1'b0; d_rd_addr = '0; d_rd_ena = 1'b0;
        m_wr_addr = '0; m_wr_data = '0; m_wr_mask = '0; m_wr_ena = 1'b0; m_rd_addr = '0; m_rd_ena = 1'b0;
        z_wr_addr = '0; z_wr_data = '0; z_wr_mask = '0; z_wr_ena = 1'b0; z_rd_addr = '0; z_rd_ena = 1'b0;
        q_wr_addr = '0; q_wr_data = '0; q_wr_mask = '0; q_wr_ena = 1'b0; q_rd_addr = '0; q_rd_ena = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_d", 32'(d_rd_data), 32'h0);
        chk("rst_m1", 32'(m1_rd_data), 32'h0);
        chk("rst_z", 32'(z_rd_data), 32'h0);
        chk("rst_q", 32'(q_rd_data), 32'h0);
        rst_n = 1'b1;

        // byte write, nibble reads low then high
        d_write(9'd0, 8'hA5, 8'h00);
        d_read(10'd0, nib); chk("nib0_a5", 32'(nib), 32'h5);
        d_read(10'd1, nib); chk("nib1_a5", 32'(nib), 32'hA);

        // rd_ena low holds the last value while the address moves
        @(negedge clk);
        d_rd_addr = 10'd0;
        held = d_rd_data;
        repeat (2) @(negedge clk);
        chk("hold", 32'(d_rd_data), 32'hA);

        // mask honoured with workaround, ignored natively in 8-bit write mode
        m_write(9'd3, 8'hFF, 8'h00);
        m_write(9'd3, 8'h00, 8'hF0);
        m_read(9'd3, r1, r0);
        chk("mask_f0_wa", 32'(r1), 32'hF0);
        chk("mask_f0_native", 32'(r0), 32'h00);
        m_write(9'd4, 8'hFF, 8'h00);
        m_write(9'd4, 8'h00, 8'h3C);
        m_read(9'd4, r1, r0);
        chk("mask_3c_wa", 32'(r1), 32'h3C);
        chk("mask_3c_native", 32'(r0), 32'h00);
        m_write(9'h1FF, 8'h5A, 8'h00);
        m_read(9'h1FF, r1, r0);
        chk("last_byte_wa", 32'(r1), 32'h5A);
        chk("last_byte_native", 32'(r0), 32'h5A);

        // 16-bit write mode keeps the mask even with the workaround off
        z_write(8'd6, 16'hFFFF, 16'h0000);
        z_write(8'd6, 16'h0000, 16'hFF00);
        z_read(8'd6, w16); chk("w16_mask", 32'(w16), 32'hFF00);

        // read-during-write to the same word returns pre-write contents
        z_write(8'd5, 16'hBEEF, 16'h0000);
        @(negedge clk);
        z_wr_addr = 8'd5; z_wr_data = 16'h1234; z_wr_mask = 16'h0000; z_wr_ena = 1'b1;
        z_rd_addr = 8'd5; z_rd_ena = 1'b1;
        @(negedge clk);
        z_wr_ena = 1'b0; z_rd_ena = 1'b0;
        chk("rdw_old", 32'(z_rd_data), 32'hBEEF);
        z_read(8'd5, w16); chk("rdw_new", 32'(w16), 32'h1234);

        // 2-bit writes assemble one 16-bit row, lane 0 in the low bits
        pairs = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1};
        for (int k = 0; k < 8; k++) begin
            q_write(11'(8 + k), pairs[k]);
        end
        q_read(8'd1, w16); chk("w2_row1", 32'(w16), 32'h6C39);
        q_write(11'h7FF, 2'd3);
        q_write(11'h7FE, 2'd0);
        q_read(8'hFF, w16); chk("w2_last_top", 32'(w16 >> 12), 32'hC);

        // fill every byte, then read all nibbles back in order
        for (int a = 0; a < 512; a++) begin
            exp_byte[a] = 8'((a * 29 + 7) ^ (a >> 2));
            d_write(9'(a), exp_byte[a], 8'h00);
        end
        for (int n = 0; n < 1024; n++) begin
            d_read(10'(n), nib);
            chk($sformatf("fill_nib%0d", n), 32'(nib),
                32'(n[0] ? exp_byte[n >> 1][7:4] : exp_byte[n >> 1][3:0]));
        end

        // reset in the middle of a read stream
        @(negedge clk);
        d_rd_addr = 10'd10; d_rd_ena = 1'b1;
        @(negedge clk);
        chk("stream_pre", 32'(d_rd_data), 32'(exp_byte[5][3:0]));
        d_rd_addr = 10'd11;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_d", 32'(d_rd_data), 32'h0);
        chk("async_rst_z", 32'(z_rd_data), 32'h0);
        z_wr_addr = 8'd5; z_wr_data = 16'hDEAD; z_wr_mask = 16'h0000; z_wr_ena = 1'b1;
        @(negedge clk);
        chk("rst_read_inhibit", 32'(d_rd_data), 32'h0);
        d_rd_ena = 1'b0; z_wr_ena = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'(d_rd_data), 32'h0);
        d_read(10'd11, nib); chk("post_rst_nib11", 32'(nib), 32'(exp_byte[5][7:4]));
        d_read(10'h3FF, nib); chk("post_rst_last", 32'(nib), 32'(exp_byte[511][7:4]));
        z_read(8'd5, w16); chk("rst_write_inhibit", 32'(w16), 32'h1234);
        m_read(9'd3, r1, r0); chk("post_rst_m1", 32'(r1), 32'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ice40_ebr.md
ICE40_EBR -- requirements
Module: ice40_ebr

Interface
REQ-001 Parameter READ_MODE, default 2, read geometry: 0=256x16, 1=512x8, 2=1024x4, 3=2048x2.
REQ-002 Parameter WRITE_MODE, default 1, write geometry, same encoding as READ_MODE.
REQ-003 Parameter MASK_WORKAROUND, default 1; 1 = bit mask honoured in every write geometry.
REQ-004 Derived widths: WAW=8+WRITE_MODE, WDW=16>>WRITE_MODE, RAW=8+READ_MODE, RDW=16>>READ_MODE.
REQ-005 clk  input  1  single clock for both ports; all ports sample on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 wr_addr  input  WAW  write word address.
REQ-008 wr_data  input  WDW  write data.
REQ-009 wr_mask  input  WDW  per-bit mask; 1 = bit NOT written, 0 = bit written.
REQ-010 wr_ena  input  1  write enable.
REQ-011 rd_addr  input  RAW  read word address.
REQ-012 rd_data  output  RDW  registered read data.
REQ-013 rd_ena  input  1  read enable.

Function
REQ-014 Storage SHALL be 4096 bits; write word A bit i maps to linear bit A*WDW+i; read word A bit i maps to A*RDW+i.
REQ-015 On a clk edge with wr_ena=1, each bit i with wr_mask[i]=0 SHALL take wr_data[i]; masked bits keep their value.
REQ-016 With MASK_WORKAROUND=0 and WRITE_MODE!=0, wr_mask SHALL be ignored and all WDW bits written (native hardware behaviour); WRITE_MODE=0 always honours the mask.
REQ-017 On a clk edge with rd_ena=1, rd_data SHALL load the addressed word; visible one cycle after rd_ena/rd_addr are sampled (latency 1).
REQ-018 With rd_ena=0, rd_data SHALL hold its last value.
REQ-019 Simultaneous read and write of overlapping bits in one cycle: rd_data SHALL return the old (pre-write) contents.
REQ-020 Addresses use full width; no out-of-range case exists; all-ones address is the last word, no wrap logic.
REQ-021 Read and write geometries are independent; any READ_MODE/WRITE_MODE pair (16 combinations) SHALL be supported.
REQ-022 Out-of-range parameter values (>3) SHALL be rejected at elaboration.

Reset
REQ-023 rst_n=0 SHALL asynchronously force rd_data to 0.
REQ-024 Memory contents SHALL NOT be reset; uninitialised contents are undefined.
REQ-025 While rst_n=0, writes and reads SHALL be inhibited; operation resumes on the first clk edge after deassertion.

Structure
REQ-026 A shared package SHALL hold the mode encoding constants and width functions (addr width, data width per mode).
REQ-027 One sub-module, ice40_ebr_mem, SHALL hold the 256x16 physical array with 16-bit write-enable mask; the top SHALL translate geometry: write lane = low WRITE_MODE address bits, expanded data/mask into the 16-bit lane positions; read lane selected from a registered copy of the low READ_MODE address bits.
REQ-028 Lane bit placement SHALL be such that REQ-014 linear mapping holds for all mode pairs.

Verification
REQ-029 WRITE_MODE=1, READ_MODE=2, mask=0x00: write addr 0 data 0xA5, read addr 0 then 1 -> rd_data 0x5 then 0xA, each one cycle after rd_ena.
REQ-030 WRITE_MODE=1, MASK_WORKAROUND=1: write 0xFF to addr 3, then 0x00 with mask 0xF0 -> 8-bit readback (READ_MODE=1) of addr 3 = 0xF0.
REQ-031 Same as REQ-030 with MASK_WORKAROUND=0 -> readback 0x00.
REQ-032 Fill all 512 addresses with pseudo-random bytes (mask 0x00), read 1024 nibbles sequentially -> each matches the corresponding byte half, low nibble first; last address 0x3FF correct.
REQ-033 Write 0x1234 (WRITE_MODE=0) to addr 5 while reading addr 5 (READ_MODE=0) same cycle -> old value returned; next read returns 0x1234.
REQ-034 Assert rst_n=0 mid-read stream -> rd_data 0 immediately; after release, rd_ena=0 keeps 0, memory contents intact on subsequent reads.
